fp_int_converter: RTL and testbench

//  Multi-cycle converter between IEEE-754 single precision and 32-bit two's-complement integer
//  (cvt.w.s / cvt.s.w). It feeds the FPU datapath beside FP_Adder: it packs integers into the float

---
 rtl/fp_int_converter.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fp_int_converter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_int_converter.sv
// fp_int_converter: iterative IEEE-754 single <-> int32 converter (cvt.w.s / cvt.s.w).
// One shifter bit per cycle under a start/busy/done handshake; truncation toward zero.
// QNAN_CONST / SNAN_CONST are the canonical NaN encodings shared with FP_Adder.
module fp_int_converter #(
    parameter logic [31:0] NAN_INT_RESULT  = 32'h7FFF_FFFF,
    parameter logic        SAT_ON_OVERFLOW = 1'b1,
    parameter logic [31:0] QNAN_CONST      = 32'h7FC0_0000,
    parameter logic [31:0] SNAN_CONST      = 32'h7FA0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] operand,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        qNaN,
    output logic        sNaN,
    output logic        overflow,
    output logic        inexact
);

    localparam int unsigned DW  = 32;
    localparam int unsigned EW  = 8;
    localparam int unsigned CW  = 6;

    localparam logic [EW-1:0] EXP_INT_TOP = 8'd158;   // exponent of 2^31
    localparam logic [EW-1:0] EXP_UNITY   = 8'd150;   // exponent where mantissa LSB weighs 1
    localparam logic [EW-1:0] EXP_ONE     = 8'd127;
    localparam logic [DW-1:0] INT_MIN     = 32'h8000_0000;
    localparam logic [DW-1:0] INT_MAX     = 32'h7FFF_FFFF;
    localparam logic [DW-1:0] FLT_NEG_2P31 = 32'hCF00_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] op_q, op_d;
    logic [DW-1:0] mag_q, mag_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          shl_q, shl_d;
    logic          special_q, special_d;
    logic [DW-1:0] spec_res_q, spec_res_d;
    logic          pq_q, pq_d;
    logic          ps_q, ps_d;
    logic          po_q, po_d;
    logic          sticky_q, sticky_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] result_q, result_d;
    logic          qnan_q, qnan_d;
    logic          snan_q, snan_d;
    logic          ovf_q, ovf_d;
    logic          inexact_q, inexact_d;

    logic          op_sign;
    logic [EW-1:0] op_exp;
    logic [22:0]   op_frac;
    logic [DW-1:0] op_abs;
    logic [CW-1:0] op_clz;
    logic [DW-1:0] sat_res;

    // Leading-zero count of a nonzero word (returns 32 for zero, never used)
    function automatic logic [CW-1:0] clz32(input logic [DW-1:0] v);
        logic [CW-1:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 6'(31 - i);
        end
        return n;
    endfunction

    // Field decode of the captured operand
    assign op_sign = op_q[31];
    assign op_exp  = op_q[30:23];
    assign op_frac = op_q[22:0];
    assign op_abs  = op_sign ? (32'd0 - op_q) : op_q;
    assign op_clz  = clz32(op_abs);
    assign sat_res = op_sign ? INT_MIN : INT_MAX;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            op_q       <= '0;
            mag_q      <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            shl_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            pq_q       <= 1'b0;
            ps_q       <= 1'b0;
            po_q       <= 1'b0;
            sticky_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            qnan_q     <= 1'b0;
            snan_q     <= 1'b0;
            ovf_q      <= 1'b0;
            inexact_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            op_q       <= op_d;
            mag_q      <= mag_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            shl_q      <= shl_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            pq_q       <= pq_d;
            ps_q       <= ps_d;
            po_q       <= po_d;
            sticky_q   <= sticky_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            qnan_q     <= qnan_d;
            snan_q     <= snan_d;
            ovf_q      <= ovf_d;
            inexact_q  <= inexact_d;
        end
    end

    // Next-state, classification, shifter and output staging
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        op_d       = op_q;
        mag_d      = mag_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        shl_d      = shl_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        pq_d       = pq_q;
        ps_d       = ps_q;
        po_d       = po_q;
        sticky_d   = sticky_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        qnan_d     = qnan_q;
        snan_d     = snan_q;
        ovf_d      = ovf_q;
        inexact_d  = inexact_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETUP;
                    busy_d    = 1'b1;
                    mode_d    = mode;
                    op_d      = operand;
                    qnan_d    = 1'b0;
                    snan_d    = 1'b0;
                    ovf_d     = 1'b0;
                    inexact_d = 1'b0;
                end
            end

            SETUP: begin
                // Specials resolve here with N=0; the normal path loads the shifter
                state_d    = SHIFT;
                special_d  = 1'b1;
                spec_res_d = '0;
                cnt_d      = '0;
                mag_d      = '0;
                exp_d      = EXP_INT_TOP;
                shl_d      = 1'b1;
                pq_d       = 1'b0;
                ps_d       = 1'b0;
                po_d       = 1'b0;
                sticky_d   = 1'b0;
                if (!mode_q) begin
                    if (op_q == SNAN_CONST) begin
                        ps_d       = 1'b1;
                        spec_res_d = NAN_INT_RESULT;
                    end else if (op_q == QNAN_CONST) begin
                        pq_d       = 1'b1;
                        spec_res_d = NAN_INT_RESULT;
                    end else if (op_exp == 8'hFF && op_frac == 23'd0) begin
                        po_d       = 1'b1;
                        spec_res_d = sat_res;
                    end else if (op_exp < EXP_ONE) begin
                        sticky_d   = |op_q[30:0];
                    end else if (op_q == FLT_NEG_2P31) begin
                        spec_res_d = INT_MIN;
                    end else if (op_exp >= EXP_INT_TOP) begin
                        po_d       = 1'b1;
                        spec_res_d = SAT_ON_OVERFLOW ? sat_res : NAN_INT_RESULT;
                    end else begin
                        special_d = 1'b0;
                        mag_d     = {8'd0, 1'b1, op_frac};
                        if (op_exp > EXP_UNITY) begin
                            shl_d = 1'b1;
                            cnt_d = CW'(op_exp - EXP_UNITY);
                        end else begin
                            shl_d = 1'b0;
                            cnt_d = CW'(EXP_UNITY - op_exp);
                        end
                    end
                end else if (op_q != '0) begin
                    special_d = 1'b0;
                    mag_d     = op_abs;
                    cnt_d     = op_clz;
                    shl_d     = 1'b1;
                end
            end

            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    qnan_d    = pq_q;
                    snan_d    = ps_q;
                    ovf_d     = po_q;
                    inexact_d = sticky_q | (mode_q & ~special_q & (|mag_q[7:0]));
                    if (special_q) begin
                        result_d = spec_res_q;
                    end else if (mode_q) begin
                        result_d = {op_sign, exp_q, mag_q[30:8]};
                    end else begin
                        result_d = op_sign ? (32'd0 - mag_q) : mag_q;
                    end
                end else begin
                    cnt_d = cnt_q - 6'd1;
                    if (shl_q) begin
                        mag_d = {mag_q[30:0], 1'b0};
                        exp_d = exp_q - 8'd1;
                    end else begin
                        mag_d    = {1'b0, mag_q[31:1]};
                        sticky_d = sticky_q | mag_q[0];
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign qNaN     = qnan_q;
    assign sNaN     = snan_q;
    assign overflow = ovf_q;
    assign inexact  = inexact_q;

endmodule

// File: tb/tb_fp_int_converter.sv
// Self-checking bench for fp_int_converter: arithmetic reference model, one
// compare process on every busy cycle, directed corner cases and random stimulus.
module tb_fp_int_converter;

    localparam logic [31:0] NAN_INT = 32'h7FFF_FFFF;
    localparam logic [31:0] QNAN_C  = 32'h7FC0_0000;
    localparam logic [31:0] SNAN_C  = 32'h7FA0_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [31:0] operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        qNaN;
    logic        sNaN;
    logic        overflow;
    logic        inexact;

    typedef struct packed {
        logic [31:0] res;
        logic        q;
        logic        s;
        logic        o;
        logic        x;
        logic [5:0]  n;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   exp_cyc = 0;
    bit   pending = 1'b0;
    exp_t exp_r;

    fp_int_converter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .operand  (operand),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .qNaN     (qNaN),
        .sNaN     (sNaN),
        .overflow (overflow),
        .inexact  (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: value-level arithmetic on the operand, not a shifter
    function automatic exp_t model(input logic m, input logic [31:0] op);
        exp_t   r;
        int     e;
        int     sh;
        int     p;
        longint mant;
        longint v;
        longint a;
        longint frac;
        r = '0;
        if (!m) begin
            e = int'(op[30:23]);
            if (op == SNAN_C) begin
                r.s = 1'b1; r.res = NAN_INT;
            end else if (op == QNAN_C) begin
                r.q = 1'b1; r.res = NAN_INT;
            end else if (e == 255 && op[22:0] == 23'd0) begin
                r.o = 1'b1; r.res = op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else if (e < 127) begin
                r.x = (op[30:0] != 31'd0);
            end else if (op == 32'hCF00_0000) begin
                r.res = 32'h8000_0000;
            end else if (e >= 158) begin
                r.o = 1'b1; r.res = op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                mant = longint'({1'b1, op[22:0]});
                sh   = e - 150;
                if (sh >= 0) begin
                    v   = mant * (longint'(1) << sh);
                    r.n = 6'(sh);
                end else begin
                    v   = mant / (longint'(1) << (-sh));
                    r.x = (mant % (longint'(1) << (-sh))) != 0;
                    r.n = 6'(-sh);
                end
                if (op[31]) v = -v;
                r.res = v[31:0];
            end
        end else if (op != 32'd0) begin
            a = longint'($signed(op));
            if (a < 0) a = -a;
            p = 0;
            for (int i = 0; i < 32; i++) if (a[i]) p = i;
            r.n = 6'(31 - p);
            if (p > 23) begin
                frac = a >> (p - 23);
                r.x  = (a % (longint'(1) << (p - 23))) != 0;
            end else begin
                frac = a << (23 - p);
            end
            r.res = {op[31], 8'(127 + p), frac[22:0]};
        end
        return r;
    endfunction

    // Compare process: busy on every active cycle, result/flags/latency on done
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (pending) begin
                total++;
                if (!busy) begin
                    bad++;
                    $display("FAIL busy_low cyc=%0d got busy=%0b want 1", cyc, busy);
                end
                if (done) begin
                    total++;
                    if (cyc != exp_cyc) begin
                        bad++;
                        $display("FAIL latency got cyc=%0d want cyc=%0d", cyc, exp_cyc);
                    end
                    total++;
                    if ({result, qNaN, sNaN, overflow, inexact} !=
                        {exp_r.res, exp_r.q, exp_r.s, exp_r.o, exp_r.x}) begin
                        bad++;
                        $display("FAIL result got %h q%0b s%0b o%0b x%0b want %h q%0b s%0b o%0b x%0b",
                                 result, qNaN, sNaN, overflow, inexact,
                                 exp_r.res, exp_r.q, exp_r.s, exp_r.o, exp_r.x);
                    end
                    pending = 1'b0;
                end else if (cyc >= exp_cyc) begin
                    total++;
                    bad++;
                    $display("FAIL done_timeout got no done by cyc=%0d want done at %0d", cyc, exp_cyc);
                    pending = 1'b0;
                end
            end else if (done) begin
                total++;
                bad++;
                $display("FAIL spurious_done got done=1 at cyc=%0d want 0", cyc);
            end
        end
    end

    // Hand-derived values that anchor the reference model
    task automatic pin(input logic m, input logic [31:0] op, input logic [31:0] want_res,
                       input logic [3:0] want_qsox, input int want_n);
        exp_t r;
        r = model(m, op);
        total++;
        if (r.res != want_res || {r.q, r.s, r.o, r.x} != want_qsox || int'(r.n) != want_n) begin
            bad++;
            $display("FAIL model_pin op=%h got %h qsox=%b n=%0d want %h qsox=%b n=%0d",
                     op, r.res, {r.q, r.s, r.o, r.x}, r.n, want_res, want_qsox, want_n);
        end
    endtask

    // One conversion; dbl also pulses start while busy and in the done cycle
    task automatic conv(input logic m, input logic [31:0] op, input bit dbl);
        exp_t e;
        e = model(m, op);
        @(negedge clk);
        mode    = m;
        operand = op;
        start   = 1'b1;
        exp_r   = e;
        exp_cyc = cyc + int'(e.n) + 3;
        pending = 1'b1;
        @(negedge clk);
        start   = dbl;
        mode    = 1'($urandom);
        operand = $urandom;
        @(negedge clk);
        start   = 1'b0;
        for (int i = 0; i < 80 && pending; i++) @(negedge clk);
        if (pending) begin
            total++;
            bad++;
            $display("FAIL conv_stuck op=%h got pending want done", op);
            pending = 1'b0;
        end
        if (dbl) begin
            start   = 1'b1;
            operand = $urandom;
            @(negedge clk);
            start = 1'b0;
            total++;
            if (busy) begin
                bad++;
                $display("FAIL start_in_done got busy=1 want 0");
            end
        end
        @(negedge clk);
    endtask

    logic [31:0] rop;
    logic        rm;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        operand = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, result, qNaN, sNaN, overflow, inexact} != 38'd0) begin
            bad++;
            $display("FAIL reset_state got busy%0b done%0b res=%h flags=%b want all 0",
                     busy, done, result, {qNaN, sNaN, overflow, inexact});
        end

        pin(1'b0, 32'h4049_0FDB, 32'd3,         4'b0001, 22);
        pin(1'b1, 32'h0000_0001, 32'h3F80_0000, 4'b0000, 31);
        pin(1'b1, 32'h8000_0000, 32'hCF00_0000, 4'b0000, 0);
        pin(1'b0, 32'hCF00_0000, 32'h8000_0000, 4'b0000, 0);
        pin(1'b0, 32'h4F00_0000, 32'h7FFF_FFFF, 4'b0010, 0);
        pin(1'b0, 32'hFF80_0000, 32'h8000_0000, 4'b0010, 0);
        pin(1'b0, 32'h7FC0_0000, NAN_INT,       4'b1000, 0);
        pin(1'b1, 32'h0123_4567, 32'h4B91_A2B3, 4'b0001, 7);
        pin(1'b0, 32'hBF80_0000, 32'hFFFF_FFFF, 4'b0000, 23);

        conv(1'b0, 32'h4049_0FDB, 1'b0);
        conv(1'b1, 32'h0000_0001, 1'b0);
        conv(1'b1, 32'h8000_0000, 1'b0);
        conv(1'b0, 32'hCF00_0000, 1'b0);
        conv(1'b0, 32'h4F00_0000, 1'b0);
        conv(1'b0, 32'hFF80_0000, 1'b0);
        conv(1'b0, 32'h7FC0_0000, 1'b1);
        conv(1'b0, SNAN_C,        1'b0);
        conv(1'b0, 32'h7F80_0001, 1'b0);
        conv(1'b0, 32'h7F80_0000, 1'b0);
        conv(1'b0, 32'h8000_0000, 1'b0);
        conv(1'b0, 32'h0000_0001, 1'b0);
        conv(1'b0, 32'h3F7F_FFFF, 1'b0);
        conv(1'b0, 32'h3F80_0000, 1'b0);
        conv(1'b0, 32'hBF80_0000, 1'b1);
        conv(1'b0, 32'h4EFF_FFFF, 1'b0);
        conv(1'b0, 32'hCEFF_FFFF, 1'b0);
        conv(1'b0, 32'hCF00_0001, 1'b0);
        conv(1'b1, 32'h0000_0000, 1'b0);
        conv(1'b1, 32'h7FFF_FFFF, 1'b0);
        conv(1'b1, 32'hFFFF_FFFF, 1'b0);
        conv(1'b1, 32'h00FF_FFFF, 1'b0);

        // Reset in the middle of a shift: outputs clear at once, no done
        @(negedge clk);
        mode    = 1'b1;
        operand = 32'h0123_4567;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (!busy) begin
            bad++;
            $display("FAIL mid_shift_busy got busy=0 want 1");
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, result, qNaN, sNaN, overflow, inexact} != 38'd0) begin
            bad++;
            $display("FAIL async_reset got busy%0b done%0b res=%h flags=%b want all 0",
                     busy, done, result, {qNaN, sNaN, overflow, inexact});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        conv(1'b1, 32'h0123_4567, 1'b0);

        // Randomized operands across both directions
        for (int k = 0; k < 60; k++) begin
            rm  = 1'($urandom_range(0, 1));
            rop = $urandom;
            if (rm) begin
                rop = rop >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) rop = 32'd0 - rop;
            end else begin
                case ($urandom_range(0, 3))
                    0:       rop[30:23] = 8'($urandom_range(118, 165));
                    1, 2:    rop[30:23] = 8'($urandom_range(127, 157));
                    default: rop = $urandom;
                endcase
            end
            conv(rm, rop, bit'($urandom_range(0, 7) == 0));
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
